write_ingress: RTL and testbench
================================

Name: write_ingress

Overview:
- Write-side front end of the async FIFO, in the write_clk domain, directly upstream of the write pointer/full block.
- Accepts a producer valid/ready stream into a 2-entry skid buffer.
- Issues write_incr plus memory write enable/data whenever the FIFO is not full.
- Reports a registered fill level and a programmable almost_full flag, derived from the write pointer and the synchronized read pointer.

Parameters:
- address_size, 4, FIFO depth = 2**address_size; pointers are address_size+1 bits.
- data_width, 8, payload width.

Ports:
- write_clk  input  1  write-domain clock
- wreset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  producer word valid
- in_data  input  data_width  producer word
- in_ready  output  1  block can accept a word this cycle
- write_full  input  1  registered full flag from the write pointer/full block
- write_pointer  input  address_size+1  binary write pointer from the write pointer/full block
- read_pointer_s  input  address_size+1  read pointer, already synchronized into write_clk
- almost_full_thresh  input  address_size+1  almost_full level, quasi-static
- write_incr  output  1  advance write pointer; memory write strobe
- mem_wdata  output  data_width  data written at the current write address
- fill_level  output  address_size+1  occupied entries, 0..2**address_size
- almost_full  output  1  fill_level >= almost_full_thresh

Behaviour:
- Reset: clock write_clk; reset wreset_n, asynchronous, active-low.
- Reset values:
  - buffer count = 0, in_ready = 0, fill_level = 0, almost_full = 0.
  - write_incr = 0 (combinational from count), mem_wdata = 0.
  - in_ready rises at the first posedge after reset deasserts.
- Skid buffer:
  - 2 entries, FIFO order, count 0..2.
  - Push = in_valid & in_ready. Pop = write_incr.
  - Push and pop in the same cycle leaves count unchanged and preserves order.
- in_ready: registered; next value = (count_next != 2).
- Write issue:
  - write_incr = (count != 0) & ~write_full, combinational.
  - mem_wdata = head entry.
  - Minimum latency: word accepted at edge N is written at edge N+1.
- Full interaction: while write_full = 1, write_incr = 0 and the buffer holds. The buffer fills to 2, then in_ready drops. No word is ever lost or duplicated.
- Fill level:
  - fill_level <= (write_pointer - read_pointer_s) mod 2**(address_size+1), registered.
  - One cycle behind the pointers; handles wrap via the extra MSB.
- almost_full: registered, = (fill_next >= almost_full_thresh). A threshold of 0 forces constant 1.
- Reset mid-operation: buffered words are discarded and all state returns to reset values immediately.

Optional Feature:
- Macro WRITE_INGRESS_STALL_STAT_EN.
- Defined: adds output stall_cycles[15:0]:
  - Increments on every cycle with count == 2 & write_full & in_valid.
  - Saturates at 16'hFFFF.
  - Resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- fifo_pkg holds:
  - Default ADDRESS_SIZE/DATA_WIDTH localparams.
  - Typedef ptr_t (address_size+1 bits).
  - A fill-level function (pointer subtract modulo).
- Sub-module write_skid_buf: the 2-entry buffer with count, push/pop, head output and registered ready.

Test Plan (address_size=4, data_width=8):
- Reset held 3 cycles, then released → in_ready=0, write_incr=0, fill_level=0, almost_full=0 during reset; in_ready=1 one edge after release.
- Stream 0x00..0x11 continuously, read_pointer_s=0:
  - 16 write_incr pulses carrying 0x00..0x0F, then write_full.
  - 0x10 and 0x11 held in the buffer; in_ready=0; fill_level=16.
- Threshold 12 with the same stream → almost_full rises the cycle after fill_level would reach 12; deasserts when read_pointer_s advances so fill drops to 11.
- Wrap: write_pointer=5'b10010, read_pointer_s=5'b00011 → fill_level=15 next cycle.
- From the full state with 2 words buffered, read_pointer_s +1 → write_full drops; 0x10 is written next cycle; 0x11 waits for the next free slot; order preserved.
- wreset_n pulsed low while buffer count=2 → count=0, in_ready=0, write_incr=0 immediately; buffered words are never written.

Source files
------------

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the write side of the async FIFO.
//   ADDRESS_SIZE / DATA_WIDTH : default geometry (depth = 2**ADDRESS_SIZE)
//   ptr_t                     : binary pointer with one extra wrap bit
//   SKID_DEPTH                : number of entries in the ingress skid buffer
//   fill_of()                 : occupied entries from write/read pointers
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int ADDRESS_SIZE = 4;
  localparam int DATA_WIDTH   = 8;

  typedef logic [ADDRESS_SIZE:0] ptr_t;

  // Skid buffer occupancy encodings
  localparam logic [1:0] SKID_EMPTY = 2'd0;
  localparam logic [1:0] SKID_ONE   = 2'd1;
  localparam logic [1:0] SKID_DEPTH = 2'd2;

  // The extra MSB makes a plain modulo subtraction correct across wrap:
  // the difference is always in 0..2**ADDRESS_SIZE for legal pointers.
  function automatic ptr_t fill_of(input ptr_t wr_ptr, input ptr_t rd_ptr);
    return ptr_t'(wr_ptr - rd_ptr);
  endfunction

endpackage

// File: rtl/write_ingress_if.sv
// ---------------------------------------------------------------------------
// write_ingress_if
// Producer valid/ready stream into the FIFO write front end.
//   in_valid : producer word valid
//   in_data  : producer word
//   in_ready : consumer can take a word this cycle
// Modports: master = producer side, slave = write_ingress side.
// ---------------------------------------------------------------------------
interface write_ingress_if #(
  parameter int data_width = 8
);

  logic                  in_valid;
  logic [data_width-1:0] in_data;
  logic                  in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/write_skid_buf.sv
// ---------------------------------------------------------------------------
// write_skid_buf
// Two-entry FIFO-ordered skid buffer with a registered ready.
// Ports:
//   write_clk, wreset_n : clock, async active-low reset
//   push_valid_i        : producer valid (push = push_valid_i & ready_o)
//   push_data_i         : producer word
//   pop_i               : head consumed this cycle (only asserted when count != 0)
//   ready_o             : registered, high when the buffer will not be full
//   count_o             : occupancy 0..2
//   head_o              : oldest buffered word
// ---------------------------------------------------------------------------
module write_skid_buf
  import fifo_pkg::*;
#(
  parameter int data_width = DATA_WIDTH
) (
  input  logic                  write_clk,
  input  logic                  wreset_n,
  input  logic                  push_valid_i,
  input  logic [data_width-1:0] push_data_i,
  input  logic                  pop_i,
  output logic                  ready_o,
  output logic [1:0]            count_o,
  output logic [data_width-1:0] head_o
);

  logic [1:0]            count_q, count_d;
  logic [data_width-1:0] head_q, head_d;
  logic [data_width-1:0] tail_q, tail_d;
  logic                  ready_q, ready_d;
  logic                  push;

  assign push = push_valid_i & ready_q;

  // Next-state for the two slots. The head slot always holds the oldest
  // word; a pop shifts the tail forward. A simultaneous push and pop keeps
  // the count and appends behind whatever remains, so ordering is kept.
  // Ready is computed from the next count so it is already low in the cycle
  // the buffer becomes full.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case ({push, pop_i})
      2'b10: begin
        if (count_q == SKID_EMPTY) head_d = push_data_i;
        else                       tail_d = push_data_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == SKID_DEPTH) begin
          head_d = tail_q;
          tail_d = push_data_i;
        end else begin
          head_d = push_data_i;
        end
      end
      default: ;
    endcase
    ready_d = (count_d != SKID_DEPTH);
  end

  // Ready resets low and rises at the first edge after reset release.
  always_ff @(posedge write_clk or negedge wreset_n) begin
    if (!wreset_n) begin
      count_q <= SKID_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ready_q <= ready_d;
    end
  end

  assign ready_o = ready_q;
  assign count_o = count_q;
  assign head_o  = head_q;

endmodule

// File: rtl/write_ingress.sv
// ---------------------------------------------------------------------------
// write_ingress
// Write-side front end of the async FIFO (write_clk domain). Buffers the
// producer stream in a 2-entry skid buffer and issues one memory write plus
// write pointer increment per cycle while the FIFO is not full. Also reports
// a registered fill level and almost_full flag.
// Ports:
//   write_clk, wreset_n : clock, async active-low reset
//   in_bus              : producer valid/ready stream (slave modport)
//   write_full          : registered full flag from the pointer/full block
//   write_pointer       : binary write pointer
//   read_pointer_s      : read pointer synchronized into write_clk
//   almost_full_thresh  : almost_full level (quasi-static)
//   write_incr          : advance write pointer / memory write strobe
//   mem_wdata           : word written at the current write address
//   fill_level          : occupied entries, registered
//   almost_full         : registered fill >= threshold
//   stall_cycles        : only with WRITE_INGRESS_STALL_STAT_EN defined;
//                         saturating count of cycles the producer was
//                         blocked by a full FIFO
// ---------------------------------------------------------------------------
module write_ingress
  import fifo_pkg::*;
#(
  parameter int address_size = ADDRESS_SIZE,
  parameter int data_width   = DATA_WIDTH
) (
  input  logic                    write_clk,
  input  logic                    wreset_n,
  write_ingress_if.slave          in_bus,
  input  logic                    write_full,
  input  logic [address_size:0]   write_pointer,
  input  logic [address_size:0]   read_pointer_s,
  input  logic [address_size:0]   almost_full_thresh,
  output logic                    write_incr,
  output logic [data_width-1:0]   mem_wdata,
  output logic [address_size:0]   fill_level,
  output logic                    almost_full
`ifdef WRITE_INGRESS_STALL_STAT_EN
  ,
  output logic [15:0]             stall_cycles
`endif
);

  logic [1:0]            skid_count;
  logic [data_width-1:0] skid_head;
  logic [address_size:0] fill_q, fill_d;
  logic                  almost_full_q, almost_full_d;

  write_skid_buf #(
    .data_width (data_width)
  ) u_skid (
    .write_clk    (write_clk),
    .wreset_n     (wreset_n),
    .push_valid_i (in_bus.in_valid),
    .push_data_i  (in_bus.in_data),
    .pop_i        (write_incr),
    .ready_o      (in_bus.in_ready),
    .count_o      (skid_count),
    .head_o       (skid_head)
  );

  // A write is issued from the buffer head whenever something is buffered
  // and the pointer block is not reporting full; the pop of the skid buffer
  // is the same strobe, so a stalled FIFO simply holds the buffer.
  assign write_incr = (skid_count != SKID_EMPTY) & ~write_full;
  assign mem_wdata  = skid_head;

  // The package helper is sized for the default geometry; other geometries
  // use the same modulo subtraction directly.
  generate
    if (address_size == ADDRESS_SIZE) begin : g_fill_pkg
      assign fill_d = fill_of(write_pointer, read_pointer_s);
    end else begin : g_fill_inline
      assign fill_d = write_pointer - read_pointer_s;
    end
  endgenerate

  // A zero threshold makes the compare always true, so almost_full is
  // constantly high outside reset.
  assign almost_full_d = (fill_d >= almost_full_thresh);

  // Fill level and almost_full are registered, one cycle behind the
  // pointers, so both flags change on the same edge.
  always_ff @(posedge write_clk or negedge wreset_n) begin
    if (!wreset_n) begin
      fill_q        <= '0;
      almost_full_q <= 1'b0;
    end else begin
      fill_q        <= fill_d;
      almost_full_q <= almost_full_d;
    end
  end

  assign fill_level  = fill_q;
  assign almost_full = almost_full_q;

`ifdef WRITE_INGRESS_STALL_STAT_EN
  logic [15:0] stall_q, stall_d;
  logic        stall_event;

  assign stall_event = (skid_count == SKID_DEPTH) & write_full & in_bus.in_valid;

  // Saturating counter of cycles where the producer is blocked purely
  // because the FIFO behind the full skid buffer is full.
  always_comb begin
    stall_d = stall_q;
    if (stall_event && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge write_clk or negedge wreset_n) begin
    if (!wreset_n) stall_q <= '0;
    else           stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_write_ingress.sv
// ---------------------------------------------------------------------------
// tb_write_ingress
// Directed bench for write_ingress (address_size=4, data_width=8). The bench
// also stands in for the downstream write pointer/full block: it counts
// write_incr pulses into a write pointer and registers a full flag, or the
// pointers/full flag can be driven by hand for the wrap and reset steps.
// ---------------------------------------------------------------------------
module tb_write_ingress;

  logic       write_clk = 1'b0;
  logic       wreset_n;
  logic       write_full;
  logic [4:0] write_pointer;
  logic [4:0] read_pointer_s;
  logic [4:0] almost_full_thresh;
  logic       write_incr;
  logic [7:0] mem_wdata;
  logic [4:0] fill_level;
  logic       almost_full;
`ifdef WRITE_INGRESS_STALL_STAT_EN
  logic [15:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  logic       manualMode;
  logic [4:0] wpManual;
  logic       fullManual;
  logic [4:0] wpEnv;
  logic [4:0] wpEnvNext;
  logic       fullEnv;

  logic       acc;
  int         nextWr;
  int         strayWrites;

  write_ingress_if #(.data_width(8)) inBus ();

  write_ingress #(
    .address_size (4),
    .data_width   (8)
  ) dut (
    .write_clk          (write_clk),
    .wreset_n           (wreset_n),
    .in_bus             (inBus),
    .write_full         (write_full),
    .write_pointer      (write_pointer),
    .read_pointer_s     (read_pointer_s),
    .almost_full_thresh (almost_full_thresh),
    .write_incr         (write_incr),
    .mem_wdata          (mem_wdata),
    .fill_level         (fill_level),
    .almost_full        (almost_full)
`ifdef WRITE_INGRESS_STALL_STAT_EN
    ,
    .stall_cycles       (stall_cycles)
`endif
  );

  always #5 write_clk = ~write_clk;

  // Stand-in write pointer / registered full block
  assign wpEnvNext = wpEnv + 5'(write_incr);

  always_ff @(posedge write_clk or negedge wreset_n) begin
    if (!wreset_n) begin
      wpEnv   <= '0;
      fullEnv <= 1'b0;
    end else begin
      wpEnv   <= wpEnvNext;
      fullEnv <= ((wpEnvNext - read_pointer_s) == 5'd16);
    end
  end

  assign write_pointer = manualMode ? wpManual : wpEnv;
  assign write_full    = manualMode ? fullManual : fullEnv;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge write_clk);
    @(negedge write_clk);
  endtask

  initial begin
    // Reset held for three cycles
    wreset_n           = 1'b0;
    manualMode         = 1'b0;
    wpManual           = '0;
    fullManual         = 1'b0;
    read_pointer_s     = '0;
    almost_full_thresh = 5'd12;
    inBus.in_valid     = 1'b1;
    inBus.in_data      = 8'h00;
    nextWr             = 0;
    strayWrites        = 0;
    repeat (3) @(posedge write_clk);
    @(negedge write_clk);
    checkOutput("rst_in_ready", 32'(inBus.in_ready), 32'd0);
    checkOutput("rst_write_incr", 32'(write_incr), 32'd0);
    checkOutput("rst_fill", 32'(fill_level), 32'd0);
    checkOutput("rst_almost_full", 32'(almost_full), 32'd0);
    checkOutput("rst_wdata", 32'(mem_wdata), 32'd0);

    wreset_n = 1'b1;
    #1;
    checkOutput("ready_before_first_edge", 32'(inBus.in_ready), 32'd0);

    // Stream 0x00..0x11 against read pointer 0, threshold 12
    for (int cyc = 0; cyc < 25; cyc++) begin
      acc = inBus.in_valid & inBus.in_ready;
      if (write_incr) begin
        checkOutput("stream_wdata", 32'(mem_wdata), 32'(nextWr[7:0]));
        nextWr++;
      end
      if (fill_level == 5'd11) checkOutput("af_low_at_11", 32'(almost_full), 32'd0);
      if (fill_level == 5'd12) checkOutput("af_high_at_12", 32'(almost_full), 32'd1);
      @(posedge write_clk);
      #1;
      if (cyc == 0) checkOutput("ready_after_first_edge", 32'(inBus.in_ready), 32'd1);
      if (acc) begin
        if (inBus.in_data == 8'h11) inBus.in_valid = 1'b0;
        else                        inBus.in_data = inBus.in_data + 8'd1;
      end
      @(negedge write_clk);
    end
    checkOutput("stream_write_count", 32'(nextWr), 32'd16);
    checkOutput("stream_full", 32'(write_full), 32'd1);
    checkOutput("stream_in_ready", 32'(inBus.in_ready), 32'd0);
    checkOutput("stream_write_incr", 32'(write_incr), 32'd0);
    checkOutput("stream_fill", 32'(fill_level), 32'd16);
    checkOutput("stream_head", 32'(mem_wdata), 32'h10);
    checkOutput("stream_almost_full", 32'(almost_full), 32'd1);
`ifdef WRITE_INGRESS_STALL_STAT_EN
    checkOutput("stall_zero", 32'(stall_cycles), 32'd0);
`endif

    // One slot frees: 0x10 written, 0x11 waits for the next slot
    read_pointer_s = 5'd1;
    stepCycle();
    checkOutput("free1_write_incr", 32'(write_incr), 32'd1);
    checkOutput("free1_wdata", 32'(mem_wdata), 32'h10);
    checkOutput("free1_fill", 32'(fill_level), 32'd15);
    stepCycle();
    checkOutput("free1_refull", 32'(write_full), 32'd1);
    checkOutput("free1_hold_incr", 32'(write_incr), 32'd0);
    checkOutput("free1_next_head", 32'(mem_wdata), 32'h11);
    checkOutput("free1_ready", 32'(inBus.in_ready), 32'd1);
    read_pointer_s = 5'd2;
    stepCycle();
    checkOutput("free2_write_incr", 32'(write_incr), 32'd1);
    checkOutput("free2_wdata", 32'(mem_wdata), 32'h11);
    stepCycle();
    checkOutput("free2_drained", 32'(write_incr), 32'd0);
    checkOutput("free2_fill", 32'(fill_level), 32'd15);

    // almost_full deasserts when fill drops from 12 to 11 (write pointer 18)
    read_pointer_s = 5'd6;
    stepCycle();
    checkOutput("af_fill12", 32'(fill_level), 32'd12);
    checkOutput("af_set_12", 32'(almost_full), 32'd1);
    read_pointer_s = 5'd7;
    stepCycle();
    checkOutput("af_fill11", 32'(fill_level), 32'd11);
    checkOutput("af_clear_11", 32'(almost_full), 32'd0);

    // Pointer wrap cases
    manualMode     = 1'b1;
    fullManual     = 1'b0;
    wpManual       = 5'b10010;
    read_pointer_s = 5'b00011;
    stepCycle();
    checkOutput("wrap_fill_a", 32'(fill_level), 32'd15);
    checkOutput("wrap_af_a", 32'(almost_full), 32'd1);
    wpManual       = 5'b00010;
    read_pointer_s = 5'b10011;
    stepCycle();
    checkOutput("wrap_fill_b", 32'(fill_level), 32'd15);

    // Threshold zero forces almost_full even when empty
    almost_full_thresh = 5'd0;
    wpManual           = 5'd5;
    read_pointer_s     = 5'd5;
    stepCycle();
    checkOutput("thr0_fill", 32'(fill_level), 32'd0);
    checkOutput("thr0_af", 32'(almost_full), 32'd1);
    almost_full_thresh = 5'd12;
    stepCycle();
    checkOutput("thr12_empty_af", 32'(almost_full), 32'd0);

    // Fill the skid buffer behind a full FIFO, then reset mid-operation
    fullManual     = 1'b1;
    inBus.in_valid = 1'b1;
    inBus.in_data  = 8'hA0;
    @(posedge write_clk);
    #1;
    inBus.in_data = 8'hA1;
    @(posedge write_clk);
    #1;
    inBus.in_valid = 1'b0;
    @(negedge write_clk);
    checkOutput("skid2_ready", 32'(inBus.in_ready), 32'd0);
    checkOutput("skid2_incr", 32'(write_incr), 32'd0);
    checkOutput("skid2_head", 32'(mem_wdata), 32'hA0);
    fullManual = 1'b0;
    #1;
    checkOutput("skid2_would_write", 32'(write_incr), 32'd1);
    wreset_n = 1'b0;
    #1;
    checkOutput("midrst_ready", 32'(inBus.in_ready), 32'd0);
    checkOutput("midrst_incr", 32'(write_incr), 32'd0);
    checkOutput("midrst_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("midrst_fill", 32'(fill_level), 32'd0);
    stepCycle();
    wreset_n = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (write_incr) strayWrites++;
      stepCycle();
    end
    checkOutput("midrst_no_stray_writes", 32'(strayWrites), 32'd0);
    checkOutput("midrst_ready_back", 32'(inBus.in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
